// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares the single line-wide memory port between the I-cache and D-cache miss
// paths. The D-cache has fixed priority. A streak counter stops the D-cache from
// starving a waiting I-cache. A grant is held until the adaptor responds. One
// dead DONE cycle follows each grant so the served cache can drop its request.
module cache_mem_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // I-cache side
  input  logic              arb_icache_read,
  input  logic              arb_icache_write,
  input  logic [ADDR_W-1:0] arb_icache_address,
  input  logic [LINE_W-1:0] arb_icache_wdata,
  output logic              arb_icache_resp,
  output logic [LINE_W-1:0] arb_icache_rdata,
  // D-cache side
  input  logic              arb_dcache_read,
  input  logic              arb_dcache_write,
  input  logic [ADDR_W-1:0] arb_dcache_address,
  input  logic [LINE_W-1:0] arb_dcache_wdata,
  output logic              arb_dcache_resp,
  output logic [LINE_W-1:0] arb_dcache_rdata,
  // Adaptor side
  output logic              arb_mem_read,
  output logic              arb_mem_write,
  output logic [ADDR_W-1:0] arb_mem_address,
  output logic [LINE_W-1:0] arb_mem_wdata,
  input  logic              arb_mem_resp,
  input  logic [LINE_W-1:0] arb_mem_rdata
);

  localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;   // D grants taken back-to-back while I waited
  logic                req_i;
  logic                req_d;
  logic                pick_d;

  assign req_i  = arb_icache_read | arb_icache_write;
  assign req_d  = arb_dcache_read | arb_dcache_write;
  // D wins unless I is waiting and D has already used up its streak.
  assign pick_d = req_d && (!req_i || (streak < STREAK_MAX));

  // Arbitration state machine and starvation-guard streak counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state <= GRANT_D;
            if (!req_i)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + STREAK_W'(1);
          end else if (req_i) begin
            state  <= GRANT_I;
            streak <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (arb_mem_resp)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Route the granted cache onto the memory port; idle, done and reset drive zeros.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    arb_mem_read    = 1'b0;
    arb_mem_write   = 1'b0;
    arb_mem_address = '0;
    arb_mem_wdata   = '0;
    arb_icache_resp = 1'b0;
    arb_dcache_resp = 1'b0;
    case (state)
      GRANT_I: begin
        arb_mem_read    = arb_icache_read;
        arb_mem_write   = arb_icache_write;
        arb_mem_address = arb_icache_address;
        arb_mem_wdata   = arb_icache_wdata;
        arb_icache_resp = arb_mem_resp;
      end
      GRANT_D: begin
        arb_mem_read    = arb_dcache_read;
        arb_mem_write   = arb_dcache_write;
        arb_mem_address = arb_dcache_address;
        arb_mem_wdata   = arb_dcache_wdata;
        arb_dcache_resp = arb_mem_resp;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; the per-cache resp is the only qualifier.
  assign arb_icache_rdata = arb_mem_rdata;
  assign arb_dcache_rdata = arb_mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Directed scenarios followed by a randomized phase. Each cycle the outputs are
// compared against a transaction-level model. The model tracks who owns the
// memory port and how many D grants in a row were taken while I was waiting.
module tb_cache_mem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int MAXS   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              arb_icache_read, arb_icache_write;
  logic [ADDR_W-1:0] arb_icache_address;
  logic [LINE_W-1:0] arb_icache_wdata;
  logic              arb_icache_resp;
  logic [LINE_W-1:0] arb_icache_rdata;
  logic              arb_dcache_read, arb_dcache_write;
  logic [ADDR_W-1:0] arb_dcache_address;
  logic [LINE_W-1:0] arb_dcache_wdata;
  logic              arb_dcache_resp;
  logic [LINE_W-1:0] arb_dcache_rdata;
  logic              arb_mem_read, arb_mem_write;
  logic [ADDR_W-1:0] arb_mem_address;
  logic [LINE_W-1:0] arb_mem_wdata;
  logic              arb_mem_resp;
  logic [LINE_W-1:0] arb_mem_rdata;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .MAX_D_STREAK(MAXS)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .arb_icache_read    (arb_icache_read),
    .arb_icache_write   (arb_icache_write),
    .arb_icache_address (arb_icache_address),
    .arb_icache_wdata   (arb_icache_wdata),
    .arb_icache_resp    (arb_icache_resp),
    .arb_icache_rdata   (arb_icache_rdata),
    .arb_dcache_read    (arb_dcache_read),
    .arb_dcache_write   (arb_dcache_write),
    .arb_dcache_address (arb_dcache_address),
    .arb_dcache_wdata   (arb_dcache_wdata),
    .arb_dcache_resp    (arb_dcache_resp),
    .arb_dcache_rdata   (arb_dcache_rdata),
    .arb_mem_read       (arb_mem_read),
    .arb_mem_write      (arb_mem_write),
    .arb_mem_address    (arb_mem_address),
    .arb_mem_wdata      (arb_mem_wdata),
    .arb_mem_resp       (arb_mem_resp),
    .arb_mem_rdata      (arb_mem_rdata)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who currently owns the port, plus the D streak.
  typedef enum {OWN_NONE, OWN_I, OWN_D, OWN_COOLDOWN} owner_t;
  owner_t m_owner  = OWN_NONE;
  int     m_streak = 0;

  // Bench bookkeeping
  int resp_log[$];
  int cyc        = 0;
  int first_mem  = -1;
  int first_resp = -1;
  int same_cycle = 0;
  bit seen_i, seen_d;
  // Stimulus knobs
  bit auto_adapt  = 1'b1;
  bit drop_on_rsp = 1'b1;
  bit rand_agents = 1'b0;
  bit rand_lat    = 1'b0;
  bit spurious    = 1'b0;
  int lat         = 0;
  int lat_cnt     = 0;
  logic [LINE_W-1:0] rd_pattern;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the owner: the owner's request is forwarded
  // and the owner alone sees the adaptor's resp.
  task automatic check_outputs(input string ctx);
    logic              e_rd, e_wr, e_ir, e_dr;
    logic [ADDR_W-1:0] e_a;
    logic [LINE_W-1:0] e_d;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_a = '0; e_d = '0;
    if (m_owner == OWN_I) begin
      e_rd = arb_icache_read;  e_wr = arb_icache_write;
      e_a  = arb_icache_address; e_d = arb_icache_wdata; e_ir = arb_mem_resp;
    end else if (m_owner == OWN_D) begin
      e_rd = arb_dcache_read;  e_wr = arb_dcache_write;
      e_a  = arb_dcache_address; e_d = arb_dcache_wdata; e_dr = arb_mem_resp;
    end
    check({ctx, ".mem_read"},    LINE_W'(arb_mem_read),    LINE_W'(e_rd));
    check({ctx, ".mem_write"},   LINE_W'(arb_mem_write),   LINE_W'(e_wr));
    check({ctx, ".mem_address"}, LINE_W'(arb_mem_address), LINE_W'(e_a));
    check({ctx, ".mem_wdata"},   arb_mem_wdata,            e_d);
    check({ctx, ".icache_resp"}, LINE_W'(arb_icache_resp), LINE_W'(e_ir));
    check({ctx, ".dcache_resp"}, LINE_W'(arb_dcache_resp), LINE_W'(e_dr));
    check({ctx, ".icache_rdata"}, arb_icache_rdata, arb_mem_rdata);
    check({ctx, ".dcache_rdata"}, arb_dcache_rdata, arb_mem_rdata);
  endtask

  // Advance the model by one clock using the inputs of the finished cycle.
  task automatic model_clock();
    bit ri, rd;
    ri = arb_icache_read | arb_icache_write;
    rd = arb_dcache_read | arb_dcache_write;
    case (m_owner)
      OWN_NONE: begin
        if (rd && (!ri || m_streak < MAXS)) begin
          m_owner  = OWN_D;
          m_streak = ri ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
        end else if (ri) begin
          m_owner  = OWN_I;
          m_streak = 0;
        end
      end
      OWN_I, OWN_D: if (arb_mem_resp) m_owner = OWN_COOLDOWN;
      default:      m_owner = OWN_NONE;
    endcase
  endtask

  // Adaptor stand-in: answers a pending request after `lat` cycles.
  task automatic drive_adaptor();
    if (arb_mem_read | arb_mem_write) begin
      if (lat_cnt >= lat) begin
        arb_mem_resp  = 1'b1;
        arb_mem_rdata = rd_pattern;
        lat_cnt       = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
        arb_mem_resp  = 1'b0;
        arb_mem_rdata = rand_line();
        lat_cnt++;
      end
    end else begin
      arb_mem_resp  = spurious && ($urandom_range(0, 3) == 0);
      arb_mem_rdata = rand_line();
      lat_cnt       = 0;
    end
    if (rand_agents) rd_pattern = rand_line();
  endtask

  // Random caches: start a request only when not already requesting.
  task automatic drive_agents();
    if (!arb_icache_read && $urandom_range(0, 3) == 0) begin
      arb_icache_read    = 1'b1;
      arb_icache_address = $urandom() & 32'hFFFF_FFE0;
      arb_icache_wdata   = rand_line();
    end
    if (!arb_dcache_read && !arb_dcache_write && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 1) == 1) arb_dcache_write = 1'b1;
      else                           arb_dcache_read  = 1'b1;
      arb_dcache_address = $urandom() & 32'hFFFF_FFE0;
      arb_dcache_wdata   = rand_line();
    end
  endtask

  // One clock: called at a falling edge with inputs applied, returns at the next falling edge.
  task automatic step(input string ctx);
    if (rand_agents) drive_agents();
    if (auto_adapt)  drive_adaptor();
    #1;
    check_outputs(ctx);
    seen_i = arb_icache_resp;
    seen_d = arb_dcache_resp;
    if (seen_i) resp_log.push_back(1);
    if (seen_d) resp_log.push_back(2);
    if (seen_i && seen_d) same_cycle++;
    if ((arb_mem_read | arb_mem_write) && first_mem < 0) first_mem = cyc;
    if ((seen_i | seen_d) && first_resp < 0) first_resp = cyc;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    cyc++;
    if (drop_on_rsp && seen_i) begin arb_icache_read = 1'b0; arb_icache_write = 1'b0; end
    if (drop_on_rsp && seen_d) begin arb_dcache_read = 1'b0; arb_dcache_write = 1'b0; end
  endtask

  task automatic clear_trackers();
    resp_log.delete();
    first_mem  = -1;
    first_resp = -1;
    same_cycle = 0;
  endtask

  function automatic int log_at(input int k);
    return (k < resp_log.size()) ? resp_log[k] : 0;
  endfunction

  int req_cyc;
  int exp4[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  initial begin
    reset_n = 1'b0;
    arb_icache_read = 1'b0; arb_icache_write = 1'b0;
    arb_icache_address = '0; arb_icache_wdata = '0;
    arb_dcache_read = 1'b0; arb_dcache_write = 1'b0;
    arb_dcache_address = '0; arb_dcache_wdata = '0;
    arb_mem_resp = 1'b0; arb_mem_rdata = '0;
    rd_pattern = rand_line();

    // Reset state, including a stray adaptor resp and requests while held in reset.
    @(negedge clk);
    arb_mem_resp = 1'b1; arb_dcache_read = 1'b1; arb_icache_read = 1'b1;
    #1 check_outputs("reset");
    @(negedge clk);
    arb_mem_resp = 1'b0; arb_dcache_read = 1'b0; arb_icache_read = 1'b0;
    reset_n = 1'b1;
    step("post_reset");

    // 1. I read only, latency 5, rdata pattern A.
    clear_trackers();
    lat = 5; rd_pattern = {8{32'hA5A5_0001}};
    arb_icache_read = 1'b1; arb_icache_address = 32'h0000_0040; arb_icache_wdata = rand_line();
    req_cyc = cyc;
    for (int k = 0; k < 30 && resp_log.size() < 1; k++) step("t1");
    step("t1_done"); step("t1_idle");
    check("t1_resp_count", LINE_W'(resp_log.size()), LINE_W'(1));
    check("t1_resp_owner", LINE_W'(log_at(0)), LINE_W'(1));
    check("t1_mem_latency", LINE_W'(first_mem), LINE_W'(req_cyc + 1));
    check("t1_resp_latency", LINE_W'(first_resp), LINE_W'(req_cyc + 6));

    // 2. D writeback only.
    clear_trackers();
    lat = 2; rd_pattern = rand_line();
    arb_dcache_write = 1'b1; arb_dcache_address = 32'h1000_0080;
    arb_dcache_wdata = {8{32'hBEEF_0B0B}};
    for (int k = 0; k < 30 && resp_log.size() < 1; k++) step("t2");
    step("t2_done"); step("t2_idle");
    check("t2_resp_count", LINE_W'(resp_log.size()), LINE_W'(1));
    check("t2_resp_owner", LINE_W'(log_at(0)), LINE_W'(2));

    // 3. Simultaneous requests: D first, then I, never in the same cycle.
    clear_trackers();
    lat = 1;
    arb_icache_read = 1'b1; arb_icache_address = 32'h0000_0100; arb_icache_wdata = rand_line();
    arb_dcache_read = 1'b1; arb_dcache_address = 32'h2000_0200; arb_dcache_wdata = rand_line();
    for (int k = 0; k < 40 && resp_log.size() < 2; k++) step("t3");
    step("t3_done"); step("t3_idle");
    check("t3_first", LINE_W'(log_at(0)), LINE_W'(2));
    check("t3_second", LINE_W'(log_at(1)), LINE_W'(1));
    check("t3_same_cycle", LINE_W'(same_cycle), LINE_W'(0));

    // 4. I held while D re-requests at once: four D grants, one I, repeat.
    clear_trackers();
    lat = 0; drop_on_rsp = 1'b0;
    arb_icache_read = 1'b1; arb_icache_address = 32'h0000_0300;
    arb_dcache_read = 1'b1; arb_dcache_address = 32'h3000_0400;
    for (int k = 0; k < 200 && resp_log.size() < 10; k++) step("t4");
    for (int k = 0; k < 10; k++) check($sformatf("t4_grant%0d", k), LINE_W'(log_at(k)), LINE_W'(exp4[k]));
    drop_on_rsp = 1'b1;
    for (int k = 0; k < 60 && (arb_icache_read || arb_dcache_read); k++) step("t4_drain");
    check("t4_drained", LINE_W'(arb_icache_read | arb_dcache_read), LINE_W'(0));
    step("t4_idle_a"); step("t4_idle_b");

    // 5. Reset during a D grant: outputs drop at once, no resp, clean restart.
    clear_trackers();
    lat = 20;
    arb_dcache_read = 1'b1; arb_dcache_address = 32'h4000_0040; arb_dcache_wdata = rand_line();
    step("t5_arb"); step("t5_grant"); step("t5_wait");
    #2 reset_n = 1'b0;
    m_owner = OWN_NONE; m_streak = 0;
    #1 check_outputs("t5_in_reset");
    arb_dcache_read = 1'b0; lat_cnt = 0;
    @(negedge clk);
    #1 check_outputs("t5_held");
    reset_n = 1'b1;
    @(negedge clk);
    lat = 3;
    arb_icache_read = 1'b1; arb_icache_address = 32'h0000_0500; arb_icache_wdata = rand_line();
    for (int k = 0; k < 30 && resp_log.size() < 1; k++) step("t5_after");
    step("t5_done"); step("t5_idle");
    check("t5_resp_count", LINE_W'(resp_log.size()), LINE_W'(1));
    check("t5_resp_owner", LINE_W'(log_at(0)), LINE_W'(1));

    // 6. Spurious adaptor resp while idle.
    clear_trackers();
    auto_adapt = 1'b0;
    arb_mem_resp = 1'b1; arb_mem_rdata = rand_line();
    step("t6_spurious_a"); step("t6_spurious_b");
    arb_mem_resp = 1'b0;
    step("t6_after");
    auto_adapt = 1'b1;
    check("t6_no_resp", LINE_W'(resp_log.size()), LINE_W'(0));

    // Randomized traffic with random latency and stray resps.
    rand_agents = 1'b1; rand_lat = 1'b1; spurious = 1'b1;
    for (int k = 0; k < 400; k++) step("rand");
    rand_agents = 1'b0;
    for (int k = 0; k < 60 && (arb_icache_read || arb_dcache_read || arb_dcache_write); k++)
      step("rand_drain");
    check("rand_drained", LINE_W'(arb_icache_read | arb_dcache_read | arb_dcache_write), LINE_W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
